// File: rtl/minimal_mem_pkg.sv
// ---------------------------------------------------------------------------
// minimal_mem_pkg
// Shared definitions for the minimal memory protocol initiator:
//   - state_e        : initiator FSM states (IDLE=0, ACCESS=1, RESP=2)
//   - DEF_BITSIZE_*  : default address / data / size field widths
//   - DEF_TIMEOUT    : default strobe-cycle limit before an access aborts
//   - size_to_mask() : converts an access size in bits into a data mask
// ---------------------------------------------------------------------------
package minimal_mem_pkg;

    localparam int unsigned DEF_BITSIZE_ADDR = 7;
    localparam int unsigned DEF_BITSIZE_DATA = 8;
    localparam int unsigned DEF_BITSIZE_SIZE = 4;
    localparam int unsigned DEF_TIMEOUT      = 255;

    // Widest data bus the mask helper supports.
    localparam int unsigned MASK_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // (1 << size) - 1, saturating to all ones once size covers the bus width.
    // The result is MASK_MAX_W wide; callers truncate to their data width.
    function automatic logic [MASK_MAX_W-1:0] size_to_mask(input int unsigned size,
                                                           input int unsigned width);
        logic [MASK_MAX_W-1:0] ones;
        ones = '1;
        if (size >= width) begin
            return ones >> (MASK_MAX_W - width);
        end
        return (MASK_MAX_W'(1) << size) - MASK_MAX_W'(1);
    endfunction

endpackage

// File: rtl/minimal_mem_watchdog.sv
// ---------------------------------------------------------------------------
// minimal_mem_watchdog
// Timeout counter for one access. Cleared when a command is accepted, counts
// each strobe cycle without responder completion, and flags expiry once it
// has reached TIMEOUT-1 (i.e. in the TIMEOUT-th strobe cycle).
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear_i      : restart the count from zero (priority over enable_i)
//   enable_i     : advance the count by one this cycle
//   expired_o    : count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module minimal_mem_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned    CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            // Saturate at the limit so a stray enable can never wrap.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/minimal_mem_initiator.sv
// ---------------------------------------------------------------------------
// minimal_mem_initiator
// Single-channel initiator for the minimal memory protocol. Accepts one
// command at a time, holds the read or write strobe until the responder
// raises M_DataRdy (or the watchdog expires), then emits a one-cycle
// response carrying masked read data or a timeout error.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_we/addr/wdata/size : command fields (size is in bits)
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata/rsp_error : masked read data / timeout flag
//   Mout_*              : protocol strobes, address, write data, size
//   M_Rdata_ram/M_DataRdy : responder read data and completion
//   busy                : high whenever not in IDLE
// All outputs decode registers only; no cmd_* or M_* input reaches an output
// combinationally. BITSIZE_data is limited to 64 bits by the mask helper.
// ---------------------------------------------------------------------------
module minimal_mem_initiator
    import minimal_mem_pkg::*;
#(
    parameter int unsigned BITSIZE_addr = DEF_BITSIZE_ADDR,
    parameter int unsigned BITSIZE_data = DEF_BITSIZE_DATA,
    parameter int unsigned BITSIZE_size = DEF_BITSIZE_SIZE,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [BITSIZE_addr-1:0] cmd_addr,
    input  logic [BITSIZE_data-1:0] cmd_wdata,
    input  logic [BITSIZE_size-1:0] cmd_size,
    output logic                    rsp_valid,
    output logic [BITSIZE_data-1:0] rsp_rdata,
    output logic                    rsp_error,
    output logic                    Mout_oe_ram,
    output logic                    Mout_we_ram,
    output logic [BITSIZE_addr-1:0] Mout_addr_ram,
    output logic [BITSIZE_data-1:0] Mout_Wdata_ram,
    output logic [BITSIZE_size-1:0] Mout_data_ram_size,
    input  logic [BITSIZE_data-1:0] M_Rdata_ram,
    input  logic                    M_DataRdy,
    output logic                    busy
);

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [BITSIZE_addr-1:0] addr_q, addr_d;
    logic [BITSIZE_data-1:0] wdata_q, wdata_d;
    logic [BITSIZE_size-1:0] size_q, size_d;
    logic [BITSIZE_data-1:0] rdata_q, rdata_d;
    logic                    error_q, error_d;

    logic                    wd_clear;
    logic                    wd_enable;
    logic                    wd_expired;
    logic [MASK_MAX_W-1:0]   mask_full;
    logic [BITSIZE_data-1:0] rdata_masked;

    minimal_mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Mask is built from the registered size, so it is stable through ACCESS.
    assign mask_full    = size_to_mask(32'(size_q), BITSIZE_data);
    assign rdata_masked = BITSIZE_data'(64'(M_Rdata_ram) & mask_full);

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d     = cmd_we;
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    size_d   = cmd_size;
                    rdata_d  = '0;
                    error_d  = 1'b0;
                    wd_clear = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                // Completion is checked before expiry so a ready arriving in
                // the limit cycle still counts as a success.
                if (M_DataRdy) begin
                    rdata_d = we_q ? '0 : rdata_masked;
                    error_d = 1'b0;
                    state_d = RESP;
                end else if (wd_expired) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_enable = 1'b1;
                end
            end
            RESP: begin
                // Response fields only live for the single valid cycle.
                rdata_d = '0;
                error_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign cmd_ready          = (state_q == IDLE);
    assign busy               = (state_q != IDLE);
    assign rsp_valid          = (state_q == RESP);
    assign rsp_rdata          = rdata_q;
    assign rsp_error          = error_q;
    // oe and we derive from one registered bit, so they can never overlap.
    assign Mout_oe_ram        = (state_q == ACCESS) && !we_q;
    assign Mout_we_ram        = (state_q == ACCESS) &&  we_q;
    assign Mout_addr_ram      = addr_q;
    assign Mout_Wdata_ram     = wdata_q;
    assign Mout_data_ram_size = size_q;

endmodule

// File: tb/tb_minimal_mem_initiator.sv
module tb_minimal_mem_initiator;

    localparam int TO   = 4;
    localparam int MAXC = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [3:0] cmd_size;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_error;
    logic       Mout_oe_ram;
    logic       Mout_we_ram;
    logic [6:0] Mout_addr_ram;
    logic [7:0] Mout_Wdata_ram;
    logic [3:0] Mout_data_ram_size;
    logic [7:0] M_Rdata_ram;
    logic       M_DataRdy;
    logic       busy;

    int checks = 0;
    int errors = 0;

    minimal_mem_initiator #(
        .BITSIZE_addr (7),
        .BITSIZE_data (8),
        .BITSIZE_size (4),
        .TIMEOUT      (TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_we             (cmd_we),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .cmd_size           (cmd_size),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_error          (rsp_error),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    // Reference mask: low 'size' bits set, all ones once size reaches 8.
    function automatic logic [7:0] exp_mask(input int size);
        if (size >= 8) return 8'hFF;
        return 8'((1 << size) - 1);
    endfunction

    // Issues one command and plays a responder that raises M_DataRdy in cycle
    // rdy_cycle (0 = never). Cycle n is the period after the n-th edge counted
    // from the acceptance edge. Outputs are sampled at falling edges.
    task automatic run_access(input logic we, input logic [6:0] addr,
                              input logic [7:0] wdata, input logic [3:0] size,
                              input int rdy_cycle, input logic [7:0] resp_data,
                              output int rsp_cyc, output logic [7:0] rdata,
                              output logic err, output int s_first, output int s_last,
                              output logic hold_ok, output logic excl_ok,
                              output logic after_ok);
        int waited;
        waited = 0; rsp_cyc = -1; rdata = 8'h00; err = 1'b0;
        s_first = -1; s_last = -1; hold_ok = 1'b1; excl_ok = 1'b1; after_ok = 1'b0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_size = size;
        @(negedge clock);
        // Scramble the command bus to show the fields were registered.
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = 7'($urandom);
        cmd_wdata = 8'($urandom); cmd_size = 4'($urandom);
        for (int c = 1; c <= MAXC; c++) begin
            if (Mout_oe_ram && Mout_we_ram) excl_ok = 1'b0;
            if (Mout_oe_ram || Mout_we_ram) begin
                if (s_first < 0) s_first = c;
                s_last = c;
                if (Mout_we_ram !== we || Mout_addr_ram !== addr ||
                    Mout_Wdata_ram !== wdata || Mout_data_ram_size !== size)
                    hold_ok = 1'b0;
            end
            if (rsp_valid) begin
                rsp_cyc = c; rdata = rsp_rdata; err = rsp_error;
                break;
            end
            M_DataRdy   = (c == rdy_cycle);
            M_Rdata_ram = (c == rdy_cycle) ? resp_data : 8'($urandom);
            @(negedge clock);
        end
        M_DataRdy = 1'b0;
        if (rsp_cyc > 0) begin
            @(negedge clock);
            after_ok = !rsp_valid && cmd_ready && !Mout_oe_ram && !Mout_we_ram;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_error !== 1'b0 ||
            rsp_rdata !== 8'h00 || Mout_oe_ram !== 1'b0 || Mout_we_ram !== 1'b0 ||
            Mout_addr_ram !== 7'h00 || Mout_Wdata_ram !== 8'h00 || Mout_data_ram_size !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b rv=%b err=%b rd=%h oe=%b we=%b a=%h wd=%h sz=%h, required ready=1 and all else 0",
                     cmd_ready, busy, rsp_valid, rsp_error, rsp_rdata, Mout_oe_ram, Mout_we_ram,
                     Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write();
        int rc, sf, sl; logic [7:0] rd; logic er, ho, ex, af;
        run_access(1'b1, 7'h05, 8'hA5, 4'd8, 1, 8'h00, rc, rd, er, sf, sl, ho, ex, af);
        checks++;
        if (sf !== 1 || sl !== 1) begin errors++; $display("FAIL write_strobe_window: cycles %0d..%0d, required 1..1", sf, sl); end
        checks++;
        if (ho !== 1'b1 || ex !== 1'b1) begin errors++; $display("FAIL write_bus_hold: hold=%b excl=%b, required 1/1", ho, ex); end
        checks++;
        if (rc !== 2 || er !== 1'b0 || rd !== 8'h00) begin
            errors++; $display("FAIL write_response: cycle=%0d err=%b rdata=%h, required 2/0/00", rc, er, rd);
        end
        checks++;
        if (af !== 1'b1) begin errors++; $display("FAIL write_after_resp: got %b, required 1", af); end
    endtask

    task automatic test_read();
        int rc, sf, sl; logic [7:0] rd; logic er, ho, ex, af;
        run_access(1'b0, 7'h05, 8'h3C, 4'd8, 2, 8'hA5, rc, rd, er, sf, sl, ho, ex, af);
        checks++;
        if (sf !== 1 || sl !== 2 || ho !== 1'b1) begin
            errors++; $display("FAIL read_strobe_window: cycles %0d..%0d hold=%b, required 1..2 hold=1", sf, sl, ho);
        end
        checks++;
        if (rc !== 3 || er !== 1'b0 || rd !== 8'hA5) begin
            errors++; $display("FAIL read_response: cycle=%0d err=%b rdata=%h, required 3/0/a5", rc, er, rd);
        end
    endtask

    task automatic test_masked_read();
        int rc, sf, sl; logic [7:0] rd; logic er, ho, ex, af;
        logic [3:0] sizes [3];
        logic [7:0] want  [3];
        sizes[0] = 4'd4;  want[0] = 8'h05;
        sizes[1] = 4'd0;  want[1] = 8'h00;
        sizes[2] = 4'd12; want[2] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, 7'h11, 8'h00, sizes[i], 1, 8'hA5, rc, rd, er, sf, sl, ho, ex, af);
            checks++;
            if (rc !== 2 || er !== 1'b0 || rd !== want[i]) begin
                errors++; $display("FAIL masked_read size=%0d: cycle=%0d err=%b rdata=%h, required 2/0/%h",
                                   sizes[i], rc, er, rd, want[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int rc, sf, sl; logic [7:0] rd; logic er, ho, ex, af;
        run_access(1'b0, 7'h22, 8'h00, 4'd8, 0, 8'hFF, rc, rd, er, sf, sl, ho, ex, af);
        checks++;
        if (sf !== 1 || sl !== TO) begin errors++; $display("FAIL timeout_strobes: cycles %0d..%0d, required 1..%0d", sf, sl, TO); end
        checks++;
        if (rc !== TO + 1 || er !== 1'b1 || rd !== 8'h00) begin
            errors++; $display("FAIL timeout_response: cycle=%0d err=%b rdata=%h, required %0d/1/00", rc, er, rd, TO + 1);
        end
    endtask

    task automatic test_race_and_stray();
        int rc, sf, sl; logic [7:0] rd; logic er, ho, ex, af; logic bad;
        run_access(1'b0, 7'h33, 8'h00, 4'd8, TO, 8'h5A, rc, rd, er, sf, sl, ho, ex, af);
        checks++;
        if (rc !== TO + 1 || er !== 1'b0 || rd !== 8'h5A) begin
            errors++; $display("FAIL race_limit_ready: cycle=%0d err=%b rdata=%h, required %0d/0/5a", rc, er, rd, TO + 1);
        end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            M_DataRdy = i[0]; M_Rdata_ram = 8'($urandom);
            @(negedge clock);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        M_DataRdy = 1'b0;
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL stray_ready_idle: disturbance=%b, required 0", bad); end
        run_access(1'b0, 7'h34, 8'h00, 4'd8, 3, 8'hC3, rc, rd, er, sf, sl, ho, ex, af);
        checks++;
        if (rc !== 4 || er !== 1'b0 || rd !== 8'hC3) begin
            errors++; $display("FAIL read_after_stray: cycle=%0d err=%b rdata=%h, required 4/0/c3", rc, er, rd);
        end
    endtask

    task automatic test_reset_mid_access();
        int rc, sf, sl; logic [7:0] rd; logic er, ho, ex, af; logic seen;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 7'h44; cmd_wdata = 8'h00; cmd_size = 4'd8;
        @(negedge clock);
        cmd_valid = 1'b0;
        checks++;
        if (Mout_oe_ram !== 1'b1) begin errors++; $display("FAIL reset_mid_start: oe=%b, required 1", Mout_oe_ram); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (Mout_oe_ram !== 1'b0 || Mout_we_ram !== 1'b0 || cmd_ready !== 1'b1 ||
            rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_state: oe=%b we=%b ready=%b rv=%b busy=%b, required 0/0/1/0/0",
                               Mout_oe_ram, Mout_we_ram, cmd_ready, rsp_valid, busy);
        end
        seen = 1'b0;
        M_DataRdy = 1'b1; M_Rdata_ram = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            M_DataRdy = 1'b0;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_resp: rsp_valid seen=%b, required 0", seen); end
        run_access(1'b1, 7'h45, 8'h96, 4'd8, 1, 8'h00, rc, rd, er, sf, sl, ho, ex, af);
        checks++;
        if (rc !== 2 || er !== 1'b0 || sf !== 1 || sl !== 1 || ho !== 1'b1) begin
            errors++; $display("FAIL reset_mid_followup: cycle=%0d err=%b strobes %0d..%0d hold=%b, required 2/0/1..1/1",
                               rc, er, sf, sl, ho);
        end
    endtask

    // Random back-to-back traffic against a memory-backed responder with a
    // random completion delay; expectations come from the protocol rules.
    task automatic test_random_back_to_back();
        logic [7:0] mem [128];
        int rc, sf, sl, rdy, exp_rc; logic [7:0] rd, exp_rd, wdata; logic er, ho, ex, af, we, ok;
        logic [6:0] addr; logic [3:0] size;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
            size = 4'($urandom); rdy = $urandom_range(0, TO + 2);
            ok     = (rdy >= 1 && rdy <= TO);
            exp_rc = ok ? rdy + 1 : TO + 1;
            exp_rd = (ok && !we) ? (mem[addr] & exp_mask(int'(size))) : 8'h00;
            run_access(we, addr, wdata, size, rdy, mem[addr], rc, rd, er, sf, sl, ho, ex, af);
            if (ok && we) mem[addr] = wdata;
            checks++;
            if (rc !== exp_rc || er !== !ok || rd !== exp_rd) begin
                errors++; $display("FAIL rand_resp[%0d] we=%b sz=%0d rdy=%0d: cycle=%0d err=%b rdata=%h, required %0d/%b/%h",
                                   n, we, size, rdy, rc, er, rd, exp_rc, !ok, exp_rd);
            end
            checks++;
            if (sf !== 1 || sl !== exp_rc - 1 || ho !== 1'b1 || ex !== 1'b1 || af !== 1'b1) begin
                errors++; $display("FAIL rand_bus[%0d]: strobes %0d..%0d hold=%b excl=%b after=%b, required 1..%0d/1/1/1",
                                   n, sf, sl, ho, ex, af, exp_rc - 1);
            end
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_size = '0; M_Rdata_ram = '0; M_DataRdy = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_masked_read();
        test_timeout();
        test_race_and_stray();
        test_reset_mid_access();
        test_random_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish in time");
        $fatal(1, "time limit");
    end

endmodule
